// File: rtl/down_timer_pkg.sv
// timer_pkg: shared state encoding and parameter defaults for the down_timer
// slice (down_timer, down_timer_if, timer_prescaler).
package timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_DONE
  } timer_state_t;

  localparam int TIMER_WIDTH_DEFAULT          = 32;
  localparam int TIMER_PRESCALE_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle between a timer user (master) and the
// down_timer (slave). The prescale field exists only when TIMER_PRESCALER_EN
// is defined.
interface down_timer_if
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
`ifdef TIMER_PRESCALER_EN
  , parameter int PRESCALE_WIDTH = TIMER_PRESCALE_WIDTH_DEFAULT
`endif
);

  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             periodic;
  logic             stop;
  logic             tick;
  logic             ack;
`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescale;
`endif
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             expired;
  logic             pending;
  logic             overrun;

  modport master (
`ifdef TIMER_PRESCALER_EN
    output prescale,
`endif
    output start, load_value, periodic, stop, tick, ack,
    input  q, busy, expired, pending, overrun
  );

  modport slave (
`ifdef TIMER_PRESCALER_EN
    input  prescale,
`endif
    input  start, load_value, periodic, stop, tick, ack,
    output q, busy, expired, pending, overrun
  );

endinterface

// File: rtl/down_timer_prescaler.sv
// timer_prescaler: divides raw ticks so that every (prescale+1)th raw tick
// seen while enabled becomes one effective tick. prescale=0 passes ticks
// straight through. Only compiled with TIMER_PRESCALER_EN.
`ifdef TIMER_PRESCALER_EN
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = TIMER_PRESCALE_WIDTH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear_i,
  input  logic                      enable_i,
  input  logic                      tick_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      tick_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;

  // Count raw ticks; >= keeps the divider from running away if prescale
  // is lowered below the current count mid-run.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && tick_i) begin
      if (cnt_q >= prescale_i) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot and periodic
// (auto-reload) modes, a one-cycle expiry pulse, a sticky pending flag and
// overrun detection. Defining TIMER_PRESCALER_EN adds the prescale field and
// a raw-tick prescaler in front of the decrement.
//
// state  | meaning
// T_IDLE | not counting; q holds its last value
// T_RUN  | counting down on qualified ticks; busy=1
// T_DONE | one-shot expired; q==0, waiting for ack or start
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
`ifdef TIMER_PRESCALER_EN
  , parameter int PRESCALE_WIDTH = TIMER_PRESCALE_WIDTH_DEFAULT
`endif
) (
  input  logic        clk,
  input  logic        reset,
  down_timer_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] reload_q;
  logic             periodic_q;
  logic             expired_q;
  logic             pending_q;
  logic             overrun_q;
  logic             eff_tick;

`ifdef TIMER_PRESCALER_EN
  timer_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (bus.start | bus.stop),
    .enable_i   (state_q == T_RUN),
    .tick_i     (bus.tick),
    .prescale_i (bus.prescale),
    .tick_o     (eff_tick)
  );
`else
  assign eff_tick = bus.tick;
`endif

  // Main FSM: start beats everything, stop beats a tick, and an expiry in
  // the same cycle as ack keeps pending set (later assignment wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= T_IDLE;
      q_q        <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      expired_q  <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.ack) begin
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (bus.start) begin
        q_q        <= bus.load_value;
        reload_q   <= bus.load_value;
        periodic_q <= bus.periodic;
        state_q    <= T_RUN;
      end else begin
        case (state_q)
          T_RUN: begin
            if (bus.stop) begin
              state_q <= T_IDLE;
            end else if (eff_tick) begin
              if (q_q > ONE) begin
                q_q <= q_q - ONE;
              end else begin
                // q==1, or q==0 left over from a zero load
                expired_q <= 1'b1;
                pending_q <= 1'b1;
                overrun_q <= overrun_q | (pending_q & ~bus.ack);
                if (periodic_q && (reload_q != '0)) begin
                  q_q <= reload_q;
                end else begin
                  q_q     <= '0;
                  state_q <= T_DONE;
                end
              end
            end
          end
          T_DONE: begin
            if (bus.ack) state_q <= T_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.q       = q_q;
  assign bus.busy    = (state_q == T_RUN);
  assign bus.expired = expired_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer; the decrementing, expiry-signalling counterpart of the shared up-counter element.
- Used by the pipelined core for timer interrupts, multi-cycle unit timeouts and peripheral delays.
- Counts a programmed value down to zero on qualified ticks and reports a one-cycle expiry pulse plus a sticky pending flag.
- Supports one-shot and periodic (auto-reload) modes.

Parameters:
- WIDTH, 32, counter and load-value width in bits.
- PRESCALE_WIDTH, 8, prescaler width; used only with TIMER_PRESCALER_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  load load_value and begin counting.
- load_value  in  WIDTH  initial count and periodic reload value.
- periodic  in  1  sampled on start; 1 = auto-reload, 0 = one-shot.
- stop  in  1  abort counting, hold q.
- tick  in  1  decrement strobe, qualified by RUN state.
- ack  in  1  clear pending and overrun.
- prescale  in  PRESCALE_WIDTH  divider value; present only with TIMER_PRESCALER_EN.
- q  out  WIDTH  current count.
- busy  out  1  high in RUN.
- expired  out  1  one-cycle pulse on reaching zero.
- pending  out  1  sticky expiry flag.
- overrun  out  1  expiry occurred while pending was already set.

Behaviour:
- Reset: asynchronous, active-high.
  - State is IDLE.
  - q, busy, expired, pending, overrun, the stored reload value and the mode bit are all 0.
- States: IDLE, RUN, DONE. busy = (state==RUN). q is registered.
- start (any state):
  - Next cycle: q=load_value, reload=load_value, mode=periodic, state=RUN.
  - start has priority over stop, tick and expiry in the same cycle.
  - load_value==0 is treated as expiry on the first qualified tick: expired pulses, then one-shot handling regardless of the periodic input.
- RUN, tick high:
  - q>1: q<=q-1.
  - q==1, or q==0 from a zero load: expired=1 for exactly one cycle (the cycle after the tick edge, aligned with q update). pending<=1.
    - One-shot: q<=0, state=DONE.
    - Periodic with reload≠0: q<=reload, stay RUN.
- RUN, tick low: q holds.
- stop in RUN: state=IDLE, q holds, pending/overrun untouched. stop in IDLE/DONE has no effect.
- overrun: set when an expiry occurs while pending is already 1, including pending set on the same cycle ack is low.
- ack: clears pending and overrun. DONE moves to IDLE.
  - If ack and a new expiry coincide, set wins: pending stays 1, overrun unchanged.
- DONE: tick ignored, q==0, waits for ack or start.
- Ticks in IDLE/DONE are ignored.
- Arithmetic: unsigned, no wrap. q never decrements below 0.
- Reset asserted mid-count aborts immediately; no expiry pulse is generated.

Optional Feature:
- Macro: TIMER_PRESCALER_EN.
- With macro:
  - Adds the prescale port and an internal PRESCALE_WIDTH prescale counter.
  - The effective tick fires on every (prescale+1)th raw tick in RUN.
  - The prescale counter clears on start, stop and reset.
  - prescale=0 gives pass-through.
- Without macro: tick directly qualifies the decrement; no prescale port; no extra logic.

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] timer_state_t {T_IDLE, T_RUN, T_DONE}.
  - Localparam defaults for WIDTH and PRESCALE_WIDTH.
- Sub-module timer_prescaler: counter with clear, raw tick in, effective tick out. Instantiated only under TIMER_PRESCALER_EN.
- Everything else lives in down_timer.

Test Plan:
- One-shot: start with load_value=3, periodic=0, tick held high. Required: q goes 3,2,1,0; expired pulses once when q becomes 0; busy falls; pending stays 1 until ack; then IDLE.
- Periodic: load_value=2, periodic=1, continuous ticks. Required: q=2,1,2,1,…; expired pulses every 2 ticks. Leaving ack low causes overrun=1 on the second expiry; one ack clears both flags.
- Stop/resume: load 5, 2 ticks (q=3), stop, 4 ticks. Required: q stays 3, busy=0, no expiry. New start with 1 then one tick gives expired.
- Priority: start (load 7) and tick in the same cycle gives q=7. ack coincident with an expiry leaves pending=1.
- Async reset: assert reset mid-count at q=4. Required: outputs are 0 immediately, before the next clk edge, and no expired pulse follows reset release.
- Prescaler (macro on): prescale=2, load 2, continuous ticks. Required: decrement every 3rd tick; expired after 6 raw ticks.
